// File: rtl/demux1_2_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Pointer width for a power-of-two FIFO depth; a 1-deep FIFO still needs one bit.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demux1_2_buf_if.sv
// Input stream plus two output streams of the buffered demultiplexer.
interface demux1_2_buf_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  // Producer and both consumers seen from outside the demultiplexer.
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface

// File: rtl/demux1_2_buf_sync_fifo.sv
// Small synchronous FIFO with a registered head (no fall-through) and unreset storage.
module sync_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = ptr_bits(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 stream demultiplexer: in_sel steers each word into one of two FIFOs.
module demux1_2_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  demux1_2_buf_if.slave  bus
);

  logic [1:0]       full;
  logic [1:0]       empty;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             accept;
  logic             push0;
  logic             push1;
  logic             pop0;
  logic             pop1;

  // in_ready depends only on the selected FIFO, never on in_valid.
  assign bus.in_ready = (bus.in_sel == SEL_OUT1) ? !full[1] : !full[0];

  assign accept = bus.in_valid && bus.in_ready;
  assign push0  = accept && (bus.in_sel == SEL_OUT0);
  assign push1  = accept && (bus.in_sel == SEL_OUT1);
  assign pop0   = bus.out0_valid && bus.out0_ready;
  assign pop1   = bus.out1_valid && bus.out1_ready;

  assign bus.out0_valid = !empty[0];
  assign bus.out1_valid = !empty[1];
  assign bus.out0_data  = empty[0] ? '0 : rdata0;
  assign bus.out1_data  = empty[1] ? '0 : rdata1;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .wdata (bus.in_data),
    .rdata (rdata0),
    .full  (full[0]),
    .empty (empty[0])
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .wdata (bus.in_data),
    .rdata (rdata1),
    .full  (full[1]),
    .empty (empty[1])
  );

  property p_producer_stable;
    @(posedge clk) disable iff (rst)
      (bus.in_valid && !bus.in_ready) |=> ($stable(bus.in_data) && $stable(bus.in_sel));
  endproperty

  a_producer_stable: assert property (p_producer_stable);

endmodule

// File: tb/tb_demux1_2_buf.sv
// Scoreboard bench for demux1_2_buf: driver queues expected words, a negedge monitor checks outputs.
module tb_demux1_2_buf;
  import demux_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux1_2_buf_if #(.WIDTH(DATA_WIDTH)) bus ();

  demux1_2_buf #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  data_t       exp0[$];
  data_t       exp1[$];
  logic        stalled[2] = '{1'b0, 1'b0};
  data_t       held[2];
  logic        wrap_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic mon_chan(input int unsigned n, input logic v, input logic r, input data_t d);
    data_t e;
    if (v) begin
      if (stalled[n]) check($sformatf("out%0d_hold_data", n), d, held[n]);
      if (r) begin
        if ((n == 0) ? (exp0.size() == 0) : (exp1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL out%0d_unexpected: got %0h, expected no word at %0t", n, d, $time);
        end else begin
          e = (n == 0) ? exp0.pop_front() : exp1.pop_front();
          check($sformatf("out%0d_data", n), d, e);
        end
      end
      stalled[n] = !r;
      held[n]    = d;
    end else begin
      if (stalled[n]) check($sformatf("out%0d_hold_valid", n), v, 1);
      check($sformatf("out%0d_idle_data", n), d, 0);
      stalled[n] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      mon_chan(0, bus.out0_valid, bus.out0_ready, bus.out0_data);
      mon_chan(1, bus.out1_valid, bus.out1_ready, bus.out1_data);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic sel, input data_t d);
    int unsigned waited = 0;
    logic        done   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (sel) exp1.push_back(d);
        else     exp0.push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready, expected accept of %0h at %0t", d, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out0_valid", bus.out0_valid, 0);
    check("rst_out0_data", bus.out0_data, 0);
    check("rst_out1_valid", bus.out1_valid, 0);
    check("rst_out1_data", bus.out1_data, 0);
    check("rst_in_ready_sel0", bus.in_ready, 1);
    bus.in_sel = 1'b1;
    #1 check("rst_in_ready_sel1", bus.in_ready, 1);
    bus.in_sel = 1'b0;
    @(posedge clk);
    #1;

    // routing
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    send(1'b0, 8'hA5);
    check("route_out0_valid", bus.out0_valid, 1);
    check("route_out0_data", bus.out0_data, 8'hA5);
    check("route_out1_valid", bus.out1_valid, 0);
    send(1'b1, 8'h3C);
    check("route_out1_valid", bus.out1_valid, 1);
    check("route_out1_data", bus.out1_data, 8'h3C);
    check("route_out0_drained", bus.out0_valid, 0);

    // full / backpressure on out0 only
    bus.out0_ready = 1'b0;
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    check("full_in_ready_sel0", bus.in_ready, 0);
    check("full_out0_head", bus.out0_data, 8'h11);
    send(1'b1, 8'h33);
    check("full_out1_data", bus.out1_data, 8'h33);

    // simultaneous push and pop on FIFO0
    bus.out0_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 8'h44);
    bus.out0_ready = 1'b0;
    check("pushpop_out0_valid", bus.out0_valid, 1);
    check("pushpop_out0_data", bus.out0_data, 8'h44);
    check("pushpop_in_ready", bus.in_ready, 1);
    bus.out0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // pointer wrap with toggling consumer
    bus.out1_ready = 1'b0;
    wrap_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * DEPTH + 1; i++) send(1'b1, data_t'($urandom));
        wrap_done = 1'b1;
      end
      begin
        int unsigned c = 0;
        while (!wrap_done && c < 200) begin
          @(posedge clk);
          #1;
          bus.out1_ready = ~bus.out1_ready;
          c++;
        end
      end
    join
    bus.out1_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    check("wrap_drained", exp1.size(), 0);

    // random soak honouring the producer rule
    acc = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!(bus.in_valid && !acc)) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_sel   = 1'($urandom_range(0, 1));
        bus.in_data  = data_t'($urandom);
      end
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        if (bus.in_sel) exp1.push_back(bus.in_data);
        else            exp0.push_back(bus.in_data);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (DEPTH + 3) @(posedge clk);
    #1;
    check("soak_q0_empty", exp0.size(), 0);
    check("soak_q1_empty", exp1.size(), 0);

    // reset mid-stream with one word in each FIFO
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    send(1'b0, 8'h5A);
    send(1'b1, 8'hC3);
    check("pre_rst_out0_valid", bus.out0_valid, 1);
    check("pre_rst_out1_valid", bus.out1_valid, 1);
    #2 rst = 1'b1;
    exp0.delete();
    exp1.delete();
    #1;
    check("midrst_out0_valid", bus.out0_valid, 0);
    check("midrst_out0_data", bus.out0_data, 0);
    check("midrst_out1_valid", bus.out1_valid, 0);
    check("midrst_out1_data", bus.out1_data, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_out0_valid", bus.out0_valid, 0);
    check("post_rst_out1_valid", bus.out1_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
